bcd_display_scan: RTL and testbench

- Consumer of the four 4-bit display codes produced by the elevator status encoder (floor, door state, action).
- Time-multiplexes them onto a 4-digit common-anode 7-segment display with active-low anodes and segments.
- Latches all four codes once per refresh frame, so a frame never mixes old and new status.
- Inserts a dead-time blank between digits (anti-ghosting) and can blink selected digits.

---
 rtl/bcd_display_scan.sv | 115 +++++++++++
 tb/tb_bcd_display_scan.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed 7-segment driver for the elevator status codes.
// Codes are latched once per frame, and each digit slot starts with a short dark gap.
module bcd_display_scan #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_FRAMES = 62
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] BCD1,
    input  logic [3:0] BCD2,
    input  logic [3:0] BCD3,
    input  logic [3:0] BCD4,
    input  logic [3:0] blink_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int             CW        = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]  BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [7:0]     BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [7:0]    blink_cnt;
    logic          blink_ph;
    logic [3:0]    lat [4];
    logic [3:0]    lbl;

    logic          slot_end;
    logic          frame_start;
    logic          frame_end;
    logic [6:0]    seg_dec;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;

    assign slot_end    = (cnt == CNT_LAST);
    assign frame_start = (cnt == '0) && (idx == 2'd0);
    assign frame_end   = slot_end && (idx == 2'd3);
    assign dp          = 1'b1;

    always_comb begin
        seg_dec = 7'h7F;
        case (lat[idx])
            4'd0:    seg_dec = 7'b1000000;
            4'd1:    seg_dec = 7'b1111001;
            4'd2:    seg_dec = 7'b0100100;
            4'd3:    seg_dec = 7'b0110000;
            4'd4:    seg_dec = 7'b0011001;
            4'd5:    seg_dec = 7'b0010010;
            4'd6:    seg_dec = 7'b0000010;
            4'd7:    seg_dec = 7'b1111000;
            4'd8:    seg_dec = 7'b0000000;
            4'd9:    seg_dec = 7'b0010000;
            default: seg_dec = 7'h7F;
        endcase
    end

    // A blinking digit in its off-phase keeps its anode selected but stays dark.
    always_comb begin
        an_next  = 4'hF;
        seg_next = 7'h7F;
        if (cnt >= BLANK_END) begin
            an_next = ~(4'b0001 << idx);
            if (!(lbl[idx] && blink_ph)) begin
                seg_next = seg_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            idx       <= 2'd0;
            blink_cnt <= 8'd0;
            blink_ph  <= 1'b0;
            lbl       <= 4'b0000;
            an        <= 4'hF;
            seg       <= 7'h7F;
            for (int i = 0; i < 4; i++) begin
                lat[i] <= 4'hF;
            end
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (frame_start) begin
                lat[0] <= BCD1;
                lat[1] <= BCD2;
                lat[2] <= BCD3;
                lat[3] <= BCD4;
                lbl    <= blink_en;
            end

            if (frame_end) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= 8'd0;
                    blink_ph  <= ~blink_ph;
                end else begin
                    blink_cnt <= blink_cnt + 8'd1;
                end
            end

            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan: a time-since-reset model predicts every output cycle.
module tb_bcd_display_scan;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int BF    = 2;
    localparam int FRAME = 4 * DIV;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] bcd1, bcd2, bcd3, bcd4, blink_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    exp_t       sb [$];
    int         checks = 0;
    int         errors = 0;
    int         t = 0;
    logic [3:0] mlat [4];
    logic [3:0] mlbl;

    bcd_display_scan #(
        .REFRESH_DIV (DIV),
        .BLANK_CYCLES(BLANK),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .BCD1    (bcd1),
        .BCD2    (bcd2),
        .BCD3    (bcd3),
        .BCD4    (bcd4),
        .blink_en(blink_en),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] c);
        case (c)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s at %0t (t=%0d): got %0h expected %0h", tag, $time, t, obs, expv);
        end
    endtask

    // Drives one clock cycle, predicting the output from the cycle count since reset release.
    task automatic applyStimulus(input logic rst);
        exp_t e;
        exp_t got;
        int   pos;
        int   d;
        int   f;
        logic off;
        reset = rst;
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        if (rst) begin
            t = 0;
        end else begin
            pos = t % DIV;
            d   = (t / DIV) % 4;
            f   = t / FRAME;
            if (t % FRAME == 0) begin
                mlat[0] = bcd1;
                mlat[1] = bcd2;
                mlat[2] = bcd3;
                mlat[3] = bcd4;
                mlbl    = blink_en;
            end
            off = mlbl[d] && ((f / BF) % 2 == 1);
            if (pos >= BLANK) begin
                e.an  = ~(4'b0001 << d);
                e.seg = off ? 7'h7F : ref_seg(mlat[d]);
            end
            t++;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        checkOutput("an", 32'(an), 32'(got.an));
        checkOutput("seg", 32'(seg), 32'(got.seg));
        checkOutput("dp", 32'(dp), 32'(got.dp));
        checkOutput("an_onehot", 32'($countones(~an) <= 1), 32'd1);
    endtask

    task automatic runCycles(input int n);
        repeat (n) applyStimulus(1'b0);
    endtask

    initial begin
        bcd1     = 4'd0;
        bcd2     = 4'd7;
        bcd3     = 4'd9;
        bcd4     = 4'd2;
        blink_en = 4'b0000;
        repeat (3) applyStimulus(1'b1);

        runCycles(FRAME);

        // Changes inside a frame must not show until the following frame.
        bcd4 = 4'd1;
        runCycles(12);
        bcd4 = 4'd4;
        bcd2 = 4'hA;
        runCycles(FRAME - 12);
        runCycles(FRAME);

        blink_en = 4'b0001;
        bcd1     = 4'd5;
        runCycles(6 * FRAME);

        for (int fr = 0; fr < 4; fr++) begin
            for (int c = 0; c < FRAME; c++) begin
                if ($urandom_range(0, 7) == 0) begin
                    bcd1     = 4'($urandom_range(0, 15));
                    bcd2     = 4'($urandom_range(0, 15));
                    bcd3     = 4'($urandom_range(0, 15));
                    bcd4     = 4'($urandom_range(0, 15));
                    blink_en = 4'($urandom_range(0, 15));
                end
                applyStimulus(1'b0);
            end
        end

        // Abort in slot 2, cycle 5, then expect a clean restart with new codes.
        runCycles(2 * DIV + 5);
        bcd1     = 4'd3;
        bcd2     = 4'd1;
        bcd3     = 4'd8;
        bcd4     = 4'd6;
        blink_en = 4'b0000;
        applyStimulus(1'b1);
        runCycles(2 * FRAME);

        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
